// File: rtl/nx_stream_arbiter_if.sv
// rtl/nx_stream_arbiter_if.sv - signal bundle between four inbound streams, one merged outbound stream
//
// Signals (directions as seen by the arbiter, i.e. the slave modport):
//   north/east/south/west_data_i   in   STREAM_WIDTH  inbound data
//   north/east/south/west_valid_i  in   1             inbound valid
//   north/east/south/west_ready_o  out  1             inbound ready
//   arb_data_o                     out  STREAM_WIDTH  merged outbound data
//   arb_dir_o                      out  2             source of outbound beat (0=N,1=E,2=S,3=W)
//   arb_valid_o                    out  1             merged outbound valid
//   arb_ready_i                    in   1             merged outbound ready
// master: the surrounding node (drives inbound streams, consumes outbound stream)
// slave:  the arbiter
interface nx_stream_arbiter_if #(
  parameter int STREAM_WIDTH = 32
);
  logic [STREAM_WIDTH-1:0] north_data_i;
  logic                    north_valid_i;
  logic                    north_ready_o;
  logic [STREAM_WIDTH-1:0] east_data_i;
  logic                    east_valid_i;
  logic                    east_ready_o;
  logic [STREAM_WIDTH-1:0] south_data_i;
  logic                    south_valid_i;
  logic                    south_ready_o;
  logic [STREAM_WIDTH-1:0] west_data_i;
  logic                    west_valid_i;
  logic                    west_ready_o;
  logic [STREAM_WIDTH-1:0] arb_data_o;
  logic [1:0]              arb_dir_o;
  logic                    arb_valid_o;
  logic                    arb_ready_i;

  modport master (
    output north_data_i, north_valid_i, input north_ready_o,
    output east_data_i,  east_valid_i,  input east_ready_o,
    output south_data_i, south_valid_i, input south_ready_o,
    output west_data_i,  west_valid_i,  input west_ready_o,
    input  arb_data_o, arb_dir_o, arb_valid_o,
    output arb_ready_i
  );

  modport slave (
    input  north_data_i, north_valid_i, output north_ready_o,
    input  east_data_i,  east_valid_i,  output east_ready_o,
    input  south_data_i, south_valid_i, output south_ready_o,
    input  west_data_i,  west_valid_i,  output west_ready_o,
    output arb_data_o, arb_dir_o, arb_valid_o,
    input  arb_ready_i
  );
endinterface

// File: rtl/nx_stream_arbiter.sv
// rtl/nx_stream_arbiter.sv - merges four direction-tagged inbound streams into one registered outbound stream
//
// Ports:
//   clk_i  in  1  clock
//   rst_i  in  1  asynchronous, active-high reset
//   bus    nx_stream_arbiter_if.slave  four inbound streams plus merged outbound stream
// Configuration:
//   NX_STREAM_ARB_ROUND_ROBIN_EN  defined: round-robin arbitration starting after the last
//                                 granted direction; undefined: fixed priority N > E > S > W.
module nx_stream_arbiter #(
  parameter int STREAM_WIDTH = 32
) (
  input logic                clk_i,
  input logic                rst_i,
  nx_stream_arbiter_if.slave bus
);

  localparam logic [1:0] DIRX_N = 2'd0;
  localparam logic [1:0] DIRX_E = 2'd1;
  localparam logic [1:0] DIRX_S = 2'd2;
  localparam logic [1:0] DIRX_W = 2'd3;

  logic [3:0]              req;
  logic [STREAM_WIDTH-1:0] in_data [4];

  logic                    slot_full_q;
  logic [STREAM_WIDTH-1:0] slot_data_q;
  logic [1:0]              slot_dir_q;

  logic                    any_req;
  logic [1:0]              gnt_dir;
  logic                    slot_free;
  logic                    load;
  logic [3:0]              ready_vec;

  // Index order matches the direction encoding.
  assign req = {bus.west_valid_i, bus.south_valid_i, bus.east_valid_i, bus.north_valid_i};
  assign in_data[DIRX_N] = bus.north_data_i;
  assign in_data[DIRX_E] = bus.east_data_i;
  assign in_data[DIRX_S] = bus.south_data_i;
  assign in_data[DIRX_W] = bus.west_data_i;

`ifdef NX_STREAM_ARB_ROUND_ROBIN_EN
  logic [1:0] last_q;
  logic [1:0] idx;

  // Search the four directions starting just after the last winner; the
  // first hit wins, and 2-bit arithmetic gives the 3->0 wrap for free.
  always_comb begin
    gnt_dir = DIRX_N;
    any_req = 1'b0;
    idx     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = last_q + 2'(k + 1);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        gnt_dir = idx;
      end
    end
  end

  // Pointer moves only on a completed input transfer, so a stalled grant
  // keeps its place in the rotation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= DIRX_W;
    end else if (load) begin
      last_q <= gnt_dir;
    end
  end
`else
  // Fixed priority: scan from lowest to highest priority so the last write
  // (lowest index, NORTH) wins.
  always_comb begin
    gnt_dir = DIRX_N;
    any_req = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) begin
        any_req = 1'b1;
        gnt_dir = 2'(k);
      end
    end
  end
`endif

  // The slot can take a beat when empty or when its current beat leaves
  // this cycle; this gives the arb_ready_i -> *_ready_o combinational path.
  assign slot_free = !slot_full_q || bus.arb_ready_i;
  assign load      = any_req && slot_free;

  always_comb begin
    ready_vec = 4'b0000;
    if (load && !rst_i) begin
      ready_vec = 4'b0001 << gnt_dir;
    end
  end

  assign bus.north_ready_o = ready_vec[DIRX_N];
  assign bus.east_ready_o  = ready_vec[DIRX_E];
  assign bus.south_ready_o = ready_vec[DIRX_S];
  assign bus.west_ready_o  = ready_vec[DIRX_W];

  // Single output slot. A load takes precedence over a drain so a beat
  // leaving and a beat arriving in the same cycle keeps the slot full.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_full_q <= 1'b0;
      slot_data_q <= '0;
      slot_dir_q  <= DIRX_N;
    end else if (load) begin
      slot_full_q <= 1'b1;
      slot_data_q <= in_data[gnt_dir];
      slot_dir_q  <= gnt_dir;
    end else if (bus.arb_ready_i) begin
      slot_full_q <= 1'b0;
    end
  end

  assign bus.arb_valid_o = slot_full_q;
  assign bus.arb_data_o  = slot_data_q;
  assign bus.arb_dir_o   = slot_dir_q;

endmodule

// File: tb/tb_nx_stream_arbiter.sv
// tb/tb_nx_stream_arbiter.sv - self-checking bench for nx_stream_arbiter (either arbitration mode)
module tb_nx_stream_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nx_stream_arbiter_if #(.STREAM_WIDTH(W)) bus ();
  nx_stream_arbiter #(.STREAM_WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] v;
    logic [3:0] exp_rdy;
    logic       exp_valid;
    logic [1:0] exp_dir;
  } vec_t;

  vec_t vecs[6];

  // Reference model: a capacity-1 queue of {dir, data} beats.
  logic [33:0] model_slot[$];
`ifdef NX_STREAM_ARB_ROUND_ROBIN_EN
  int model_last;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each direction d carries base + d so the source of any beat is visible in its data.
  task automatic drive(input logic [3:0] v, input logic rdy, input logic [31:0] base);
    bus.north_valid_i = v[0]; bus.north_data_i = base;
    bus.east_valid_i  = v[1]; bus.east_data_i  = base + 32'd1;
    bus.south_valid_i = v[2]; bus.south_data_i = base + 32'd2;
    bus.west_valid_i  = v[3]; bus.west_data_i  = base + 32'd3;
    bus.arb_ready_i   = rdy;
  endtask

  function automatic logic [3:0] readies();
    return {bus.west_ready_o, bus.south_ready_o, bus.east_ready_o, bus.north_ready_o};
  endfunction

  function automatic int exp_grant(input logic [3:0] v);
`ifdef NX_STREAM_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++) begin
      int d;
      d = (model_last + k) % 4;
      if (v[d]) return d;
    end
`else
    for (int d = 0; d < 4; d++) begin
      if (v[d]) return d;
    end
`endif
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(4'hF, 1'b0, 32'h0);
    #1;
    check("rst_ready", readies(), 4'b0000);
    check("rst_valid", bus.arb_valid_o, 1'b0);
    check("rst_data", bus.arb_data_o, 32'h0);
    check("rst_dir", bus.arb_dir_o, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    drive(4'h0, 1'b0, 32'h0);

    // From reset the round-robin search begins at NORTH, so both modes agree here.
    vecs[0] = '{v: 4'b0000, exp_rdy: 4'b0000, exp_valid: 1'b0, exp_dir: 2'd0};
    vecs[1] = '{v: 4'b0010, exp_rdy: 4'b0010, exp_valid: 1'b1, exp_dir: 2'd1};
    vecs[2] = '{v: 4'b1100, exp_rdy: 4'b0100, exp_valid: 1'b1, exp_dir: 2'd2};
    vecs[3] = '{v: 4'b1000, exp_rdy: 4'b1000, exp_valid: 1'b1, exp_dir: 2'd3};
    vecs[4] = '{v: 4'b1111, exp_rdy: 4'b0001, exp_valid: 1'b1, exp_dir: 2'd0};
    vecs[5] = '{v: 4'b0110, exp_rdy: 4'b0010, exp_valid: 1'b1, exp_dir: 2'd1};

    for (int i = 0; i < 6; i++) begin
      logic [31:0] base;
      base = 32'h1000 * (i + 1);
      do_reset();
      @(negedge clk);
      drive(vecs[i].v, 1'b1, base);
      #1;
      check($sformatf("vec%0d_ready", i), readies(), vecs[i].exp_rdy);
      @(negedge clk);
      drive(4'h0, 1'b1, 32'h0);
      #1;
      check($sformatf("vec%0d_valid", i), bus.arb_valid_o, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_dir", i), bus.arb_dir_o, vecs[i].exp_dir);
        check($sformatf("vec%0d_data", i), bus.arb_data_o, base + 32'(vecs[i].exp_dir));
      end
    end

    // Single beat from EAST.
    do_reset();
    @(negedge clk);
    drive(4'b0010, 1'b1, 32'hA5A5_0000);
    #1;
    check("single_ready", readies(), 4'b0010);
    @(negedge clk);
    drive(4'b0000, 1'b1, 32'h0);
    #1;
    check("single_valid", bus.arb_valid_o, 1'b1);
    check("single_data", bus.arb_data_o, 32'hA5A5_0001);
    check("single_dir", bus.arb_dir_o, 2'd1);
    @(negedge clk);
    #1;
    check("single_drain", bus.arb_valid_o, 1'b0);

    // Back-pressure: slot full with EAST beat, NORTH waits, then load on drain.
    do_reset();
    @(negedge clk);
    drive(4'b0010, 1'b0, 32'h100);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(4'b0001, 1'b0, 32'h200);
      #1;
      check("bp_ready", readies(), 4'b0000);
      check("bp_hold", {bus.arb_valid_o, bus.arb_dir_o, bus.arb_data_o}, {1'b1, 2'd1, 32'h101});
    end
    @(negedge clk);
    drive(4'b0001, 1'b1, 32'h200);
    #1;
    check("bp_release_ready", readies(), 4'b0001);
    @(negedge clk);
    drive(4'b0000, 1'b1, 32'h0);
    #1;
    check("bp_next", {bus.arb_valid_o, bus.arb_dir_o, bus.arb_data_o}, {1'b1, 2'd0, 32'h200});

    // All four valid, downstream always ready.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      logic [1:0] ed;
      @(negedge clk);
      if (i > 0) begin
`ifdef NX_STREAM_ARB_ROUND_ROBIN_EN
        ed = 2'((i - 1) % 4);
`else
        ed = 2'd0;
`endif
        #1;
        check("all_beat", {bus.arb_valid_o, bus.arb_dir_o, bus.arb_data_o},
              {1'b1, ed, 32'(16 * (i - 1)) + 32'(ed)});
      end
      if (i < 8) begin
        drive(4'b1111, 1'b1, 32'(16 * i));
        #1;
`ifdef NX_STREAM_ARB_ROUND_ROBIN_EN
        check("all_ready", readies(), 4'b0001 << (i % 4));
`else
        check("all_ready", readies(), 4'b0001);
`endif
      end
    end

    // Wrap and skip: last grant WEST, then only EAST and SOUTH valid.
    do_reset();
    @(negedge clk);
    drive(4'b1000, 1'b1, 32'h0);
    @(negedge clk);
    drive(4'b0110, 1'b1, 32'h10);
    #1;
    check("wrap_ready1", readies(), 4'b0010);
    @(negedge clk);
    drive(4'b0110, 1'b1, 32'h20);
    #1;
    check("wrap_beat1", {bus.arb_dir_o, bus.arb_data_o}, {2'd1, 32'h11});
`ifdef NX_STREAM_ARB_ROUND_ROBIN_EN
    check("wrap_ready2", readies(), 4'b0100);
`else
    check("wrap_ready2", readies(), 4'b0010);
`endif
    @(negedge clk);
    drive(4'b0000, 1'b1, 32'h0);
    #1;
`ifdef NX_STREAM_ARB_ROUND_ROBIN_EN
    check("wrap_beat2", {bus.arb_dir_o, bus.arb_data_o}, {2'd2, 32'h22});
`else
    check("wrap_beat2", {bus.arb_dir_o, bus.arb_data_o}, {2'd1, 32'h21});
`endif

    // Reset mid-stream with a held beat.
    do_reset();
    @(negedge clk);
    drive(4'b0001, 1'b0, 32'h300);
    @(negedge clk);
    drive(4'b1111, 1'b0, 32'h400);
    #1;
    check("mid_full", bus.arb_valid_o, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_async_valid", bus.arb_valid_o, 1'b0);
    check("mid_async_ready", readies(), 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1111, 1'b1, 32'h400);
    #1;
    check("mid_first_ready", readies(), 4'b0001);
    @(negedge clk);
    drive(4'b0000, 1'b1, 32'h0);
    #1;
    check("mid_first_beat", {bus.arb_valid_o, bus.arb_dir_o, bus.arb_data_o}, {1'b1, 2'd0, 32'h400});

    // Randomized traffic against the reference model.
    do_reset();
    model_slot.delete();
`ifdef NX_STREAM_ARB_ROUND_ROBIN_EN
    model_last = 3;
`endif
    for (int n = 0; n < 2000; n++) begin
      logic [3:0]  v;
      logic        rdy;
      logic [31:0] base;
      logic        free;
      int          g;
      @(negedge clk);
      v    = 4'($urandom);
      rdy  = ($urandom_range(0, 3) != 0);
      base = $urandom;
      drive(v, rdy, base);
      #1;
      g    = exp_grant(v);
      free = (model_slot.size() == 0) || rdy;
      check("rnd_ready", readies(), (g >= 0 && free) ? (4'b0001 << g) : 4'b0000);
      check("rnd_valid", bus.arb_valid_o, model_slot.size() != 0);
      if (model_slot.size() != 0) begin
        check("rnd_beat", {bus.arb_dir_o, bus.arb_data_o}, model_slot[0]);
      end
      if (model_slot.size() != 0 && rdy) begin
        void'(model_slot.pop_front());
      end
      if (g >= 0 && free) begin
        model_slot.push_back({2'(g), base + 32'(g)});
`ifdef NX_STREAM_ARB_ROUND_ROBIN_EN
        model_last = g;
`endif
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
